// File: rtl/code_checker.sv
// Code-breaking checker: collects four 3-bit guess digits, scores them
// against a snapshotted secret code and tracks tries, win and lose.
module code_checker #(
    parameter int unsigned MAX_TRIES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] code0,
    input  logic [2:0] code1,
    input  logic [2:0] code2,
    input  logic [2:0] code3,
    input  logic [2:0] guess_digit,
    input  logic       guess_valid,
    output logic       guess_ready,
    input  logic       clear,
    output logic [2:0] exact,
    output logic [2:0] partial,
    output logic       result_valid,
    output logic [3:0] tries,
    output logic       win,
    output logic       lose
);

    typedef enum logic [2:0] {
        COLLECT = 3'd0,
        EXACT   = 3'd1,
        COUNT   = 3'd2,
        REPORT  = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [3:0][2:0]  guess_q, guess_d;
    logic [3:0][2:0]  code_q, code_d;
    logic [2:0]       val_q, val_d;
    logic [2:0]       ex_q, ex_d;
    logic [2:0]       sum_q, sum_d;
    logic [2:0]       exact_q, exact_d;
    logic [2:0]       partial_q, partial_d;
    logic [3:0]       tries_q, tries_d;
    logic             win_q, win_d;
    logic             lose_q, lose_d;

    logic [2:0] code_cnt, guess_cnt, min_cnt, sum_nx;
    logic [3:0] tries_nx;

    function automatic logic [2:0] count_of(input logic [3:0][2:0] a,
                                            input logic [2:0] v);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < 4; i++) begin
            if (a[i] == v) n = n + 3'd1;
        end
        return n;
    endfunction

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        guess_d   = guess_q;
        code_d    = code_q;
        val_d     = val_q;
        ex_d      = ex_q;
        sum_d     = sum_q;
        exact_d   = exact_q;
        partial_d = partial_q;
        tries_d   = tries_q;
        win_d     = win_q;
        lose_d    = lose_q;

        code_cnt  = count_of(code_q, val_q);
        guess_cnt = count_of(guess_q, val_q);
        min_cnt   = (code_cnt < guess_cnt) ? code_cnt : guess_cnt;
        sum_nx    = sum_q + min_cnt;
        tries_nx  = (tries_q >= 4'(MAX_TRIES)) ? tries_q : tries_q + 4'd1;

        unique case (state_q)
            COLLECT: begin
                if (clear) begin
                    idx_d = '0;
                end else if (guess_valid) begin
                    guess_d[idx_q] = guess_digit;
                    idx_d          = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        code_d  = {code3, code2, code1, code0};
                        state_d = EXACT;
                    end
                end
            end
            EXACT: begin
                ex_d = '0;
                for (int i = 0; i < 4; i++) begin
                    if (guess_q[i] == code_q[i]) ex_d = ex_d + 3'd1;
                end
                sum_d   = '0;
                val_d   = '0;
                state_d = COUNT;
            end
            COUNT: begin
                // outputs load only here so they hold until the next REPORT
                if (val_q == 3'd7) begin
                    exact_d   = ex_q;
                    partial_d = sum_nx - ex_q;
                    state_d   = REPORT;
                end else begin
                    sum_d = sum_nx;
                    val_d = val_q + 3'd1;
                end
            end
            REPORT: begin
                tries_d = tries_nx;
                if (exact_q == 3'd4) begin
                    win_d   = 1'b1;
                    state_d = DONE;
                end else if (tries_nx == 4'(MAX_TRIES)) begin
                    lose_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    idx_d   = '0;
                    state_d = COLLECT;
                end
            end
            DONE: begin
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= COLLECT;
            idx_q     <= '0;
            guess_q   <= '0;
            code_q    <= '0;
            val_q     <= '0;
            ex_q      <= '0;
            sum_q     <= '0;
            exact_q   <= '0;
            partial_q <= '0;
            tries_q   <= '0;
            win_q     <= 1'b0;
            lose_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            guess_q   <= guess_d;
            code_q    <= code_d;
            val_q     <= val_d;
            ex_q      <= ex_d;
            sum_q     <= sum_d;
            exact_q   <= exact_d;
            partial_q <= partial_d;
            tries_q   <= tries_d;
            win_q     <= win_d;
            lose_q    <= lose_d;
        end
    end

    assign guess_ready  = (state_q == COLLECT);
    assign result_valid = (state_q == REPORT);
    assign exact        = exact_q;
    assign partial      = partial_q;
    assign tries        = tries_q;
    assign win          = win_q;
    assign lose         = lose_q;

endmodule

// File: tb/tb_code_checker.sv
// Bench for code_checker: scoreboard of expected scores for the default
// instance, directed checks for a MAX_TRIES=2 instance.
module tb_code_checker;

    logic       clk = 1'b0;
    logic       rst8, rst2;
    logic [2:0] c0, c1, c2, c3, gd;
    logic       gv, clr;

    logic       rdy8, rv8, win8, lose8;
    logic [2:0] ex8, pa8;
    logic [3:0] tr8;
    logic       rdy2, rv2, win2, lose2;
    logic [2:0] ex2, pa2;
    logic [3:0] tr2;

    typedef struct {
        logic [2:0] ex;
        logic [2:0] pa;
        int         acc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   rv2_cnt = 0;
    int   acc_last = 0;
    bit   sel = 1'b0;

    code_checker u8 (
        .clk(clk), .rst(rst8),
        .code0(c0), .code1(c1), .code2(c2), .code3(c3),
        .guess_digit(gd), .guess_valid(gv), .guess_ready(rdy8),
        .clear(clr), .exact(ex8), .partial(pa8),
        .result_valid(rv8), .tries(tr8), .win(win8), .lose(lose8)
    );

    code_checker #(.MAX_TRIES(2)) u2 (
        .clk(clk), .rst(rst2),
        .code0(c0), .code1(c1), .code2(c2), .code3(c3),
        .guess_digit(gd), .guess_valid(gv), .guess_ready(rdy2),
        .clear(clr), .exact(ex2), .partial(pa2),
        .result_valid(rv2), .tries(tr2), .win(win2), .lose(lose2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", tag, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (rv8 === 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious_rv", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("exact", {29'd0, ex8}, {29'd0, e.ex});
                chk("partial", {29'd0, pa8}, {29'd0, e.pa});
                chk("latency", cyc - e.acc, 9);
            end
        end
        if (rv2 === 1'b1) rv2_cnt++;
    end

    function automatic void model(input logic [2:0] g0, g1, g2, g3,
                                  output logic [2:0] ex,
                                  output logic [2:0] pa);
        logic [2:0] g[4];
        logic [2:0] c[4];
        bit ug[4];
        bit uc[4];
        g = '{g0, g1, g2, g3};
        c = '{c0, c1, c2, c3};
        ex = 3'd0;
        pa = 3'd0;
        for (int i = 0; i < 4; i++) begin
            ug[i] = 1'b0;
            uc[i] = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            if (g[i] == c[i]) begin
                ex = ex + 3'd1;
                ug[i] = 1'b1;
                uc[i] = 1'b1;
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (!ug[i]) begin
                for (int j = 0; j < 4; j++) begin
                    if (!uc[j] && g[i] == c[j]) begin
                        pa = pa + 3'd1;
                        uc[j] = 1'b1;
                        break;
                    end
                end
            end
        end
    endfunction

    task automatic send(input logic [2:0] d);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if ((sel ? rdy2 : rdy8) === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) chk("ready_wait", 0, 1);
        gd = d;
        gv = 1'b1;
        acc_last = cyc + 1;
        @(negedge clk);
        gv = 1'b0;
    endtask

    task automatic guess8(input logic [2:0] a, b, c, d);
        exp_t e;
        model(a, b, c, d, e.ex, e.pa);
        send(a);
        send(b);
        send(c);
        send(d);
        e.acc = acc_last;
        sb.push_back(e);
    endtask

    task automatic drain();
        for (int n = 0; n < 40; n++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        chk("drain", sb.size(), 0);
        @(negedge clk);
    endtask

    task automatic guess2(input logic [2:0] a, b, c, d,
                          input logic [2:0] wex, wpa);
        bit found;
        found = 1'b0;
        send(a);
        send(b);
        send(c);
        send(d);
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (rv2 === 1'b1) begin
                found = 1'b1;
                chk("u2_exact", {29'd0, ex2}, {29'd0, wex});
                chk("u2_partial", {29'd0, pa2}, {29'd0, wpa});
                break;
            end
        end
        if (!found) chk("u2_rv_wait", 0, 1);
        @(negedge clk);
    endtask

    initial begin
        logic [2:0] r[4];
        int n0;
        rst8 = 1'b0;
        rst2 = 1'b0;
        gv = 1'b0;
        clr = 1'b0;
        gd = 3'd0;
        c0 = 3'd5; c1 = 3'd7; c2 = 3'd4; c3 = 3'd0;
        #12;
        chk("rst_exact", {29'd0, ex8}, 0);
        chk("rst_partial", {29'd0, pa8}, 0);
        chk("rst_rv", {31'd0, rv8}, 0);
        chk("rst_tries", {28'd0, tr8}, 0);
        chk("rst_win", {31'd0, win8}, 0);
        chk("rst_lose", {31'd0, lose8}, 0);
        @(negedge clk);
        rst8 = 1'b1;
        chk("rst_ready", {31'd0, rdy8}, 1);

        guess8(3'd0, 3'd4, 3'd7, 3'd5);
        guess8(3'd5, 3'd5, 3'd5, 3'd5);
        guess8(3'd7, 3'd0, 3'd1, 3'd1);
        drain();
        chk("t3_win", {31'd0, win8}, 0);
        chk("t3_lose", {31'd0, lose8}, 0);
        chk("t3_tries", {28'd0, tr8}, 3);

        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 4; i++) r[i] = 3'($urandom_range(0, 7));
            if (r[0] == c0 && r[1] == c1 && r[2] == c2 && r[3] == c3)
                r[3] = r[3] + 3'd1;
            guess8(r[0], r[1], r[2], r[3]);
        end
        drain();
        chk("t6_tries", {28'd0, tr8}, 6);
        chk("t6_ready", {31'd0, rdy8}, 1);

        guess8(3'd1, 3'd2, 3'd3, 3'd4);
        repeat (3) @(negedge clk);
        #2 rst8 = 1'b0;
        #1;
        chk("mid_rst_rv", {31'd0, rv8}, 0);
        chk("mid_rst_exact", {29'd0, ex8}, 0);
        chk("mid_rst_partial", {29'd0, pa8}, 0);
        chk("mid_rst_tries", {28'd0, tr8}, 0);
        sb.delete();
        @(negedge clk);
        rst8 = 1'b1;
        chk("mid_rst_ready", {31'd0, rdy8}, 1);

        send(3'd1);
        send(3'd2);
        gd = 3'd3;
        gv = 1'b1;
        clr = 1'b1;
        @(negedge clk);
        gv = 1'b0;
        clr = 1'b0;
        guess8(3'd5, 3'd7, 3'd4, 3'd0);
        repeat (3) @(negedge clk);
        c0 = 3'd0; c1 = 3'd0; c2 = 3'd0; c3 = 3'd0;
        drain();
        chk("win_win", {31'd0, win8}, 1);
        chk("win_lose", {31'd0, lose8}, 0);
        chk("win_tries", {28'd0, tr8}, 1);
        chk("win_ready", {31'd0, rdy8}, 0);
        c0 = 3'd5; c1 = 3'd7; c2 = 3'd4; c3 = 3'd0;
        gv = 1'b1;
        repeat (15) @(negedge clk);
        gv = 1'b0;
        chk("done_tries", {28'd0, tr8}, 1);
        chk("done_win", {31'd0, win8}, 1);
        chk("done_exact", {29'd0, ex8}, 4);

        rst8 = 1'b0;
        sel = 1'b1;
        @(negedge clk);
        rst2 = 1'b1;
        guess2(3'd1, 3'd1, 3'd1, 3'd1, 3'd0, 3'd0);
        chk("u2_t1_tries", {28'd0, tr2}, 1);
        chk("u2_t1_lose", {31'd0, lose2}, 0);
        guess2(3'd0, 3'd4, 3'd7, 3'd5, 3'd0, 3'd4);
        chk("u2_lose", {31'd0, lose2}, 1);
        chk("u2_lose_win", {31'd0, win2}, 0);
        chk("u2_lose_tries", {28'd0, tr2}, 2);
        chk("u2_lose_ready", {31'd0, rdy2}, 0);
        n0 = rv2_cnt;
        gv = 1'b1;
        repeat (20) @(negedge clk);
        gv = 1'b0;
        chk("u2_ignored_rv", rv2_cnt, n0);
        chk("u2_ignored_tries", {28'd0, tr2}, 2);

        rst2 = 1'b0;
        @(negedge clk);
        rst2 = 1'b1;
        guess2(3'd1, 3'd1, 3'd1, 3'd1, 3'd0, 3'd0);
        guess2(3'd5, 3'd7, 3'd4, 3'd0, 3'd4, 3'd0);
        chk("u2_win", {31'd0, win2}, 1);
        chk("u2_win_lose", {31'd0, lose2}, 0);
        chk("u2_win_tries", {28'd0, tr2}, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/code_checker.md
CODE_CHECKER -- requirements
Module: code_checker

Interface
REQ-001 SHALL have parameter MAX_TRIES, default 8, giving the number of guesses allowed before loss (legal range 1..15).
REQ-002 SHALL have clk  input  1  single clock; all state changes on the rising edge.
REQ-003 SHALL have rst  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have code0..code3  input  3 each  secret digits, index 0..3, sampled only as in REQ-012.
REQ-005 SHALL have guess_digit  input  3  next guess digit.
REQ-006 SHALL have guess_valid  input  1  guess_digit is offered this cycle.
REQ-007 SHALL have guess_ready  output  1  checker accepts a digit this cycle.
REQ-008 SHALL have clear  input  1  discard the partially entered guess.
REQ-009 SHALL have exact  output  3  digits correct in value and position (0..4); partial  output  3  digits correct in value only (0..4).
REQ-010 SHALL have result_valid  output  1  one-cycle pulse, new exact/partial; tries  output  4  completed guesses; win  output  1; lose  output  1.

Function
REQ-011 SHALL implement FSM states COLLECT, EXACT, COUNT, REPORT, DONE.
REQ-012 In COLLECT, SHALL assert guess_ready; a digit is accepted on an edge where guess_valid=1 and guess_ready=1; digits fill index 0,1,2,3 in order; on acceptance of index 3, SHALL snapshot code0..code3 into internal registers and go to EXACT.
REQ-013 clear=1 in COLLECT SHALL reset the digit index to 0 and take priority over a same-cycle guess_valid; clear SHALL be ignored in all other states.
REQ-014 guess_ready SHALL be 0 in EXACT, COUNT, REPORT, DONE; guess_valid there SHALL have no effect.
REQ-015 EXACT (1 cycle) SHALL compute exact = number of i in 0..3 with guess[i]==code[i], then go to COUNT.
REQ-016 COUNT SHALL iterate value v=0..7, one value per cycle (8 cycles), accumulating sum of min(count of v in code, count of v in guess); on v=7 SHALL go to REPORT; partial = accumulated sum - exact (never negative, max 4).
REQ-017 result_valid SHALL be asserted for exactly one cycle, in REPORT, the 10th cycle after the edge accepting digit 3; exact/partial SHALL be valid that cycle and hold until the next REPORT.
REQ-018 On the REPORT edge, tries SHALL increment by 1 (saturating at MAX_TRIES).
REQ-019 Leaving REPORT: if exact==4, set win=1 and go to DONE; else if updated tries==MAX_TRIES, set lose=1 and go to DONE; else go to COLLECT with digit index 0.
REQ-020 win and lose SHALL never both be 1; win has priority when the final allowed guess is correct.
REQ-021 DONE SHALL be absorbing until reset; win/lose/tries/exact/partial hold.
REQ-022 Changes on code0..code3 after the snapshot SHALL not affect the current evaluation.

Reset
REQ-023 rst=0 SHALL immediately force state COLLECT, digit index 0, exact=0, partial=0, result_valid=0, tries=0, win=0, lose=0, guess_ready=1 (after release), regardless of state, including mid-COUNT.
REQ-024 First digit acceptance SHALL be possible on the first rising edge after rst deasserts.

Verification
REQ-025 code=5,7,4,0; guess 5,7,4,0 -> result_valid 10 cycles after last digit, exact=4, partial=0, win=1, tries=1, guess_ready=0 thereafter.
REQ-026 code=5,7,4,0; guess 0,4,7,5 -> exact=0, partial=4; guess 5,5,5,5 -> exact=1, partial=0; guess 7,0,1,1 -> exact=0, partial=2; win=0, tries=3.
REQ-027 MAX_TRIES=2, two wrong guesses -> lose=1 on second REPORT, tries=2, further guess_valid ignored; correct second guess instead -> win=1, lose=0.
REQ-028 enter digits 1,2 then clear=1 with guess_valid=1 -> index resets, digit not taken; next four digits 5,7,4,0 -> exact=4.
REQ-029 assert rst during COUNT -> all outputs zero asynchronously, no result_valid pulse; after release new guess evaluates normally.
REQ-030 change code inputs to 0,0,0,0 during COUNT of guess 5,7,4,0 -> still exact=4, partial=0.
